// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the audio mix sequencer.
//   state_t    - sequencer FSM states (IDLE / SCAN / SCALE / LOAD)
//   VOL_W      - width of the master attenuation shift input
//   acc_width  - accumulator width that holds CHANNELS full-scale samples
//   saturate   - clamp a sign-extended value to a signed width
package audio_pkg;

   localparam int VOL_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      SCALE = 2'd2,
      LOAD  = 2'd3
   } state_t;

   function automatic int acc_width(input int channels, input int width);
      return width + $clog2(channels);
   endfunction

   function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                   input int width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      else
         return value;
   endfunction

endpackage

// File: rtl/audio_sample_timer.sv
// audio_sample_timer: sample-rate tick divider.
//   clk    - system clock
//   reset  - synchronous, active-high reset (counter to 0)
//   tick   - high for one cycle when the count reaches SAMPLE_DIV-1
// The counter runs 0..SAMPLE_DIV-1 and wraps, so the first tick after
// reset release lands in cycle SAMPLE_DIV-1.
module audio_sample_timer #(
   parameter int SAMPLE_DIV = 1024
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CNT_W-1:0] count;

   assign tick = (count == CNT_W'(SAMPLE_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (tick)
         count <= '0;
      else
         count <= count + 1'b1;
   end

endmodule

// File: rtl/audio_mix_sequencer.sv
// audio_mix_sequencer: once per sample period polls CHANNELS sources in
// round-robin order, sums their signed samples, applies a master
// attenuation shift, saturates to WIDTH bits and presents the result to
// the PWM modulator with a one-cycle strobe.
//   clk, reset         - system clock, synchronous active-high reset
//   ch_enable          - per-channel mix enable
//   ch_valid/ch_ready  - per-channel handshake, ready pulses in the slot
//   ch_sample          - packed signed samples, channel i at [i*WIDTH +: WIDTH]
//   volume             - arithmetic right shift 0..7 applied to the sum
//   mix_data           - held signed mix word
//   mix_strobe         - one-cycle pulse when mix_data updates
//   underrun           - sticky, an enabled channel was not valid in its slot
// Optional feature macro AUDIO_MIX_CLIP_FLAG_EN adds clip_clr (input) and
// clip (sticky saturation flag, output).
//
// state | meaning
// IDLE  | waiting for the sample tick
// SCAN  | one channel slot per cycle, accumulate enabled valid samples
// SCALE | shift, saturate, register mix word and raise strobe
// LOAD  | new mix word and strobe visible to the PWM
module audio_mix_sequencer
   import audio_pkg::*;
#(
   parameter int CHANNELS   = 4,
   parameter int WIDTH      = 12,
   parameter int SAMPLE_DIV = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [CHANNELS-1:0]         ch_enable,
   input  logic [CHANNELS-1:0]         ch_valid,
   input  logic [CHANNELS*WIDTH-1:0]   ch_sample,
   output logic [CHANNELS-1:0]         ch_ready,
   input  logic [VOL_W-1:0]            volume,
   output logic [WIDTH-1:0]            mix_data,
   output logic                        mix_strobe,
   output logic                        underrun
`ifdef AUDIO_MIX_CLIP_FLAG_EN
   ,
   input  logic                        clip_clr,
   output logic                        clip
`endif
);

   localparam int ACC_W = acc_width(CHANNELS, WIDTH);
   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   state_t                   state;
   logic [IDX_W-1:0]         idx;
   logic signed [ACC_W-1:0]  acc;
   logic                     tick;

   logic signed [WIDTH-1:0]  cur_sample;
   logic                     cur_enable;
   logic                     cur_valid;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [31:0]       shifted_ext;
   logic signed [31:0]       sat_ext;
   logic                     clipped;

   audio_sample_timer #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign cur_sample  = ch_sample[idx*WIDTH +: WIDTH];
   assign cur_enable  = ch_enable[idx];
   assign cur_valid   = ch_valid[idx];

   // >>> on a signed operand floors toward negative infinity
   assign shifted     = acc >>> volume;
   assign shifted_ext = 32'(shifted);
   assign sat_ext     = saturate(shifted_ext, WIDTH);
   assign clipped     = (sat_ext != shifted_ext);

   always_comb begin
      ch_ready = '0;
      for (int i = 0; i < CHANNELS; i++)
         ch_ready[i] = (state == SCAN) && (idx == IDX_W'(i)) && ch_enable[i];
   end

   // mix_data is registered on the SCALE->LOAD edge so word and strobe
   // appear together in the LOAD cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         acc        <= '0;
         mix_data   <= '0;
         mix_strobe <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         mix_strobe <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  acc   <= '0;
                  idx   <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (cur_enable) begin
                  if (cur_valid)
                     acc <= acc + ACC_W'(cur_sample);
                  else
                     underrun <= 1'b1;
               end
               if (idx == IDX_W'(CHANNELS - 1))
                  state <= SCALE;
               else
                  idx <= idx + 1'b1;
            end
            SCALE: begin
               mix_data   <= sat_ext[WIDTH-1:0];
               mix_strobe <= 1'b1;
               state      <= LOAD;
            end
            LOAD: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AUDIO_MIX_CLIP_FLAG_EN
   always_ff @(posedge clk) begin
      if (reset)
         clip <= 1'b0;
      else if ((state == SCALE) && clipped)
         clip <= 1'b1;
      else if (clip_clr)
         clip <= 1'b0;
   end
`endif

   // A whole sequence must fit inside one sample period.
   tick_only_in_idle: assert property (@(posedge clk) disable iff (reset)
                                       tick |-> (state == IDLE));

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// tb_audio_mix_sequencer: directed vector table plus hand sequences for
// reset abort, enable change mid-scan, free-run period and clip flag.
// Cycle 0 is the first cycle after reset release; with SAMPLE_DIV=16 and
// CHANNELS=4 the tick is cycle 15, SCAN 16..19, SCALE 20, strobe 21.
module tb_audio_mix_sequencer;

   localparam int CH  = 4;
   localparam int W   = 12;
   localparam int DIV = 16;
   localparam int STROBE_CYC = DIV - 1 + CH + 2;

   logic              clk;
   logic              reset;
   logic [CH-1:0]     ch_enable;
   logic [CH-1:0]     ch_valid;
   logic [CH*W-1:0]   ch_sample;
   logic [CH-1:0]     ch_ready;
   logic [2:0]        volume;
   logic [W-1:0]      mix_data;
   logic              mix_strobe;
   logic              underrun;
`ifdef AUDIO_MIX_CLIP_FLAG_EN
   logic              clip_clr;
   logic              clip;
`endif

   audio_mix_sequencer #(
      .CHANNELS   (CH),
      .WIDTH      (W),
      .SAMPLE_DIV (DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ch_enable  (ch_enable),
      .ch_valid   (ch_valid),
      .ch_sample  (ch_sample),
      .ch_ready   (ch_ready),
      .volume     (volume),
      .mix_data   (mix_data),
      .mix_strobe (mix_strobe),
      .underrun   (underrun)
`ifdef AUDIO_MIX_CLIP_FLAG_EN
      ,
      .clip_clr   (clip_clr),
      .clip       (clip)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  valid;
      logic [47:0] samples;
      logic [2:0]  vol;
      int          exp_mix;
      logic        exp_under;
      logic        exp_clip;
   } vec_t;

   vec_t vecs[11];

   function automatic logic [47:0] pk(input int s0, input int s1, input int s2, input int s3);
      return {12'(s3), 12'(s2), 12'(s1), 12'(s0)};
   endfunction

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step();
   endtask

   initial begin
      reset     = 1'b1;
      ch_enable = '0;
      ch_valid  = '0;
      ch_sample = '0;
      volume    = '0;
`ifdef AUDIO_MIX_CLIP_FLAG_EN
      clip_clr  = 1'b0;
`endif

      vecs[0]  = '{4'hF, 4'hF, pk(100, 200, -50, 25),       3'd0,   275, 1'b0, 1'b0};
      vecs[1]  = '{4'hF, 4'hF, pk(2047, 2047, 2047, 2047),  3'd0,  2047, 1'b0, 1'b1};
      vecs[2]  = '{4'hF, 4'hF, pk(-2048, -2048, -2048, -2048), 3'd0, -2048, 1'b0, 1'b1};
      vecs[3]  = '{4'hF, 4'hF, pk(100, 200, -50, 25),       3'd2,    68, 1'b0, 1'b0};
      vecs[4]  = '{4'hF, 4'hF, pk(-100, -200, 50, -25),     3'd2,   -69, 1'b0, 1'b0};
      vecs[5]  = '{4'h5, 4'hB, pk(300, 500, 999, 7),        3'd0,   300, 1'b1, 1'b0};
      vecs[6]  = '{4'hF, 4'hF, pk(2047, 2047, 2047, 2047),  3'd7,    63, 1'b0, 1'b0};
      vecs[7]  = '{4'hF, 4'hF, pk(2047, 2047, -2048, 0),    3'd1,  1023, 1'b0, 1'b0};
      vecs[8]  = '{4'hF, 4'hB, pk(10, 20, 30, 40),          3'd0,    70, 1'b1, 1'b0};
      vecs[9]  = '{4'hF, 4'hF, pk(-2048, -2048, -2048, -2048), 3'd3, -1024, 1'b0, 1'b0};
      vecs[10] = '{4'h0, 4'h0, pk(1, 2, 3, 4),              3'd0,     0, 1'b0, 1'b0};

      // Table-driven vectors: one full period each, from reset.
      for (int v = 0; v < 11; v++) begin
         ch_enable = vecs[v].en;
         ch_valid  = vecs[v].valid;
         ch_sample = vecs[v].samples;
         volume    = vecs[v].vol;
         do_reset();
         check($sformatf("v%0d reset mix", v), $signed(mix_data), 0);
         check($sformatf("v%0d reset underrun", v), underrun, 0);
         for (int c = 0; c <= STROBE_CYC; c++) begin
            logic [3:0] exp_rdy;
            exp_rdy = '0;
            if (cyc >= DIV && cyc < DIV + CH)
               exp_rdy = vecs[v].en & (4'b0001 << (cyc - DIV));
            check($sformatf("v%0d ready c%0d", v, cyc), ch_ready, exp_rdy);
            check($sformatf("v%0d strobe c%0d", v, cyc), mix_strobe, (cyc == STROBE_CYC));
            if (cyc == STROBE_CYC) begin
               check($sformatf("v%0d mix", v), $signed(mix_data), vecs[v].exp_mix);
               check($sformatf("v%0d underrun", v), underrun, vecs[v].exp_under);
`ifdef AUDIO_MIX_CLIP_FLAG_EN
               check($sformatf("v%0d clip", v), clip, vecs[v].exp_clip);
`endif
            end
            if (cyc < STROBE_CYC) step();
         end
      end

      // Reset during SCAN idx=2 of the second period aborts the sequence.
      ch_enable = 4'hF;
      ch_valid  = 4'hF;
      ch_sample = pk(100, 200, -50, 25);
      volume    = 3'd0;
      do_reset();
      step_to(STROBE_CYC);
      check("abort first mix", $signed(mix_data), 275);
      step_to(STROBE_CYC + DIV - 3);
      check("abort pre ready idx2", ch_ready, 4'b0100);
      reset = 1'b1;
      step();
      check("abort ready", ch_ready, 0);
      check("abort mix", $signed(mix_data), 0);
      check("abort strobe", mix_strobe, 0);
      reset = 1'b0;
      cyc = 0;
      begin
         int early;
         early = 0;
         while (cyc < STROBE_CYC) begin
            if (mix_strobe) early++;
            step();
         end
         check("abort early strobes", early, 0);
         check("abort restart strobe", mix_strobe, 1);
         check("abort restart mix", $signed(mix_data), 275);
      end

      // ch_enable change mid-scan takes effect in the next slot.
      ch_enable = 4'hF;
      do_reset();
      step_to(DIV + 1);
      ch_enable = 4'b0111;
      step();
      check("en change ready idx2", ch_ready, 4'b0100);
      step();
      check("en change ready idx3", ch_ready, 0);
      step_to(STROBE_CYC);
      check("en change mix", $signed(mix_data), 250);

      // Free run of five periods: interval, hold and sticky underrun.
      ch_enable = 4'b0101;
      ch_valid  = 4'b1011;
      ch_sample = pk(300, 500, 999, 7);
      do_reset();
      begin
         int strobes, last, hold_err, bad_int, dis_rdy;
         strobes = 0; last = 0; hold_err = 0; bad_int = 0; dis_rdy = 0;
         while (cyc <= STROBE_CYC + 4 * DIV + 3) begin
            if (ch_ready[1] || ch_ready[3]) dis_rdy++;
            if (mix_strobe) begin
               if (strobes == 0)
                  check("free first strobe cycle", cyc, STROBE_CYC);
               else if (cyc - last != DIV)
                  bad_int++;
               last = cyc;
               strobes++;
            end else if (strobes > 0 && $signed(mix_data) != 300) begin
               hold_err++;
            end
            step();
         end
         check("free strobe count", strobes, 5);
         check("free bad intervals", bad_int, 0);
         check("free hold errors", hold_err, 0);
         check("free disabled ready", dis_rdy, 0);
         check("free mix", $signed(mix_data), 300);
         check("free underrun sticky", underrun, 1);
      end

`ifdef AUDIO_MIX_CLIP_FLAG_EN
      // Clip flag holds until cleared.
      ch_enable = 4'hF;
      ch_valid  = 4'hF;
      ch_sample = pk(2047, 2047, 2047, 2047);
      do_reset();
      check("clip reset", clip, 0);
      step_to(STROBE_CYC + 3);
      check("clip held", clip, 1);
      clip_clr = 1'b1;
      step();
      clip_clr = 1'b0;
      check("clip cleared", clip, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
